uart: RTL and testbench
=======================

# uart

Memory-mapped UART responder on the rv32 data bus, serving the CPU's loads and stores from the same address/mask/value bus used by `ram` and the LED register. Serialises bytes written by the CPU onto `uart_tx` and deserialises `uart_rx` into bytes the CPU can read, with a programmable baud divisor. Its read data is zero when not selected, so `top` ORs it into the shared read-data bus.

## Interface
- `DEFAULT_DIV`, 104, reset value of the baud divisor (clocks per bit); legal range 4..65535.
- `RX_FIFO_DEPTH`, 4, RX FIFO entries when `UART_RX_FIFO_EN` is defined; power of two, 2..16.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on `clk`.
- `sel_in`  in  1  address decode hit for this block from `top`.
- `write_mask_in`  in  4  byte write strobes; all zero means read.
- `address_in`  in  32  byte address; only `[3:2]` are decoded.
- `write_value_in`  in  32  store data.
- `read_value_out`  out  32  registered load data; zero when not selected.
- `uart_rx`  in  1  serial input, asynchronous, idle high.
- `uart_tx`  out  1  serial output, idle high.

## Operation
- Register map by `address_in[3:2]`:
  - 0 DATA: a write with `mask[0]` loads TX byte `[7:0]`; a read returns `{24'b0, rx_byte}` and pops the RX byte.
  - 1 STATUS (read only): bit0 `rx_valid`, bit1 `tx_busy`, bit2 `rx_overrun`, bit3 `frame_err`, other bits 0. A read clears bits 2–3.
  - 2 DIV: `[15:0]` is R/W, with `mask[0]`/`mask[1]` writing the low/high byte. Values below 4 are clamped to 4 on write.
  - 3: reads 0; writes are ignored.
- Frame format is 8N1, LSB first. One bit lasts DIV clocks.
- TX FSM IDLE→START→DATA(8)→STOP→IDLE:
  - A DATA write in IDLE latches the byte and enters START on the next cycle; `tx_busy`=1 from that cycle until STOP completes.
  - A DATA write while busy is dropped and leaves no side effect.
- RX path:
  - `uart_rx` passes through a 2-FF synchroniser.
  - RX FSM IDLE→START→DATA(8)→STOP→IDLE. A falling edge in IDLE starts a half-bit (DIV/2, truncated) count.
  - At the START mid-point, a sampled 1 means a glitch and returns the FSM to IDLE. Otherwise the FSM samples each data bit at its mid-bit (every DIV clocks), then samples stop.
  - Stop = 0 sets `frame_err`; the byte is still stored.
  - A byte completing while storage is full is discarded and sets `rx_overrun`.
- A DIV write takes effect at the next start bit. A frame already in flight keeps its divisor.
- Reset (at any time, including mid-frame):
  - Both FSMs go to IDLE and `uart_tx`=1.
  - Sticky flags clear, RX storage empties, DIV=`DEFAULT_DIV`, `read_value_out`=0.

## Timing
- Bus accesses complete in one cycle with no wait states.
- Reads: `read_value_out` is valid in the cycle after `sel_in` is high, matching `ram`. It is 0 in any cycle following an unselected cycle.
- A DATA read pop happens on the same edge that registers the data.
- If a byte completes on the same cycle as a DATA read:
  - The pop and the push both occur; there is no overrun if the push has space after the pop.
  - In single-register mode the new byte replaces the popped one.
- A status read coinciding with a new overrun/frame error leaves that flag set. The set wins.
- TX line timing: `uart_tx` falls 1 cycle after the DATA write edge. A full frame is exactly 10×DIV cycles. `tx_busy` drops on the cycle `uart_tx` returns to idle after stop.
- RX latency: `rx_valid` rises 2 (synchroniser) + 9.5×DIV (±1) cycles after the `uart_rx` falling edge.

## Configuration
- `UART_RX_FIFO_EN` defined: RX storage is a `RX_FIFO_DEPTH`-entry FIFO with wrap-around pointers. `rx_valid` means non-empty; overrun means a push while full. The oldest data is kept.
- Not defined: a single holding register, so `RX_FIFO_DEPTH` is unused. A second byte arriving before the read sets `rx_overrun` and is discarded.

## Test plan
- Reset, then read STATUS and DIV → STATUS reads 0x0 and DIV reads 104 (0x68); `uart_tx`=1 throughout.
- Write DIV=8, then write DATA=0xA5 → `uart_tx` shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 8 cycles, 80 cycles total. `tx_busy` reads 1 mid-frame and 0 after. A second write mid-frame does not alter the waveform.
- DIV=8, drive 0x3C on `uart_rx` → STATUS=0x1, DATA read returns 0x0000003C, then STATUS=0x0.
- Drive a frame with stop bit 0 (byte 0x55) → DATA reads 0x55; STATUS bit3 is set once and clears after that read.
- With the FIFO enabled (depth 4), send 5 bytes 0x01–0x05 without reading → reads return 0x01–0x04 and `rx_overrun`=1. Without the FIFO, send 2 bytes → 0x01 is kept and `rx_overrun`=1.
- Assert `reset_n`=0 mid-TX and mid-RX → `uart_tx`=1 on the next cycle, and STATUS=0 with DIV=104 after release.

Source files
------------

// File: rtl/uart.sv
// uart: memory-mapped 8N1 UART (DATA/STATUS/DIV registers) with programmable baud divisor.
// Define UART_RX_FIFO_EN to use an RX_FIFO_DEPTH-entry RX FIFO instead of a single holding register.
module uart #(
  parameter int DEFAULT_DIV   = 104,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] address_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  input  logic        uart_rx,
  output logic        uart_tx
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t tx_state_q, rx_state_q;
  logic [15:0] div_q, div_d, div_w, tx_cnt_q, tx_div_q, rx_cnt_q, rx_div_q;
  logic [2:0] tx_bit_q, rx_bit_q;
  logic [7:0] tx_shift_q, rx_shift_q, rx_byte;
  logic tx_q, rx1_q, rx2_q, rx_prev_q, ov_q, fe_q;
  logic [31:0] rd_q, rdata;
  logic rd, data_wr, data_rd, stat_rd, div_wr, rx_push, rx_valid, pop, push_ok;
  logic unused_ok;
  assign unused_ok = ^{address_in[31:4], address_in[1:0], write_value_in[31:16], write_mask_in[3:2]};
  assign rd      = sel_in && write_mask_in == 4'b0;
  assign data_wr = sel_in && write_mask_in[0] && address_in[3:2] == 2'd0;
  assign data_rd = rd && address_in[3:2] == 2'd0;
  assign stat_rd = rd && address_in[3:2] == 2'd1;
  assign div_wr  = sel_in && |write_mask_in[1:0] && address_in[3:2] == 2'd2;
  assign div_w   = {write_mask_in[1] ? write_value_in[15:8] : div_q[15:8],
                    write_mask_in[0] ? write_value_in[7:0]  : div_q[7:0]};
  assign div_d   = div_wr ? (div_w < 16'd4 ? 16'd4 : div_w) : div_q;
  assign rx_push = rx_state_q == S_STOP && rx_cnt_q == 16'd0;
  assign uart_tx = tx_q;
  assign read_value_out = rd_q;

  always_comb begin
    rdata = 32'h0;
    case (address_in[3:2])
      2'd0: rdata = {24'h0, rx_valid ? rx_byte : 8'h0};
      2'd1: rdata = {28'h0, fe_q, ov_q, tx_state_q != S_IDLE, rx_valid};
      2'd2: rdata = {16'h0, div_q};
      default: rdata = 32'h0;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [7:0] mem_q [RX_FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  assign rx_valid = cnt_q != '0;
  assign rx_byte  = mem_q[rp_q];
  assign pop      = data_rd && rx_valid;
  assign push_ok  = rx_push && (cnt_q != (AW+1)'(RX_FIFO_DEPTH) || pop);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push_ok) mem_q[wp_q] <= rx_shift_q;
`else
  localparam int unused_depth = RX_FIFO_DEPTH;
  logic [7:0] hold_q;
  logic full_q;
  assign rx_valid = full_q;
  assign rx_byte  = hold_q;
  assign pop      = data_rd && full_q;
  assign push_ok  = rx_push && (!full_q || pop);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      hold_q <= 8'h0;
    end else begin
      full_q <= push_ok || (full_q && !pop);
      if (push_ok) hold_q <= rx_shift_q;
    end
  end
`endif

  // flag set wins over a coincident status-read clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= 16'(DEFAULT_DIV);
      rd_q  <= 32'h0;
      ov_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      rd_q  <= rd ? rdata : 32'h0;
      ov_q  <= (rx_push && !push_ok) || (ov_q && !stat_rd);
      fe_q  <= (rx_push && !rx2_q) || (fe_q && !stat_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_q <= S_IDLE;
      tx_q       <= 1'b1;
      tx_cnt_q   <= 16'h0;
      tx_div_q   <= 16'h0;
      tx_bit_q   <= 3'h0;
      tx_shift_q <= 8'h0;
    end else begin
      case (tx_state_q)
        S_IDLE: if (data_wr) begin
          tx_state_q <= S_START;
          tx_q       <= 1'b0;
          tx_shift_q <= write_value_in[7:0];
          tx_cnt_q   <= div_q - 16'd1;
          tx_div_q   <= div_q;
        end
        S_START, S_DATA: if (tx_cnt_q == 16'd0) begin
          tx_cnt_q <= tx_div_q - 16'd1;
          if (tx_state_q == S_DATA && tx_bit_q == 3'd7) begin
            tx_state_q <= S_STOP;
            tx_q       <= 1'b1;
          end else begin
            tx_bit_q   <= tx_state_q == S_START ? 3'd0 : tx_bit_q + 3'd1;
            tx_state_q <= S_DATA;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
          end
        end else tx_cnt_q <= tx_cnt_q - 16'd1;
        S_STOP: if (tx_cnt_q == 16'd0) tx_state_q <= S_IDLE; else tx_cnt_q <= tx_cnt_q - 16'd1;
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_q <= S_IDLE;
      rx1_q      <= 1'b1;
      rx2_q      <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= 16'h0;
      rx_div_q   <= 16'h0;
      rx_bit_q   <= 3'h0;
      rx_shift_q <= 8'h0;
    end else begin
      rx1_q     <= uart_rx;
      rx2_q     <= rx1_q;
      rx_prev_q <= rx2_q;
      case (rx_state_q)
        S_IDLE: if (rx_prev_q && !rx2_q) begin
          rx_state_q <= S_START;
          rx_div_q   <= div_q;
          rx_cnt_q   <= (div_q >> 1) - 16'd1;
        end
        S_START: if (rx_cnt_q == 16'd0) begin
          rx_state_q <= rx2_q ? S_IDLE : S_DATA;
          rx_cnt_q   <= rx_div_q - 16'd1;
          rx_bit_q   <= 3'd0;
        end else rx_cnt_q <= rx_cnt_q - 16'd1;
        S_DATA: if (rx_cnt_q == 16'd0) begin
          rx_shift_q <= {rx2_q, rx_shift_q[7:1]};
          rx_cnt_q   <= rx_div_q - 16'd1;
          rx_bit_q   <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
        end else rx_cnt_q <= rx_cnt_q - 16'd1;
        S_STOP: if (rx_cnt_q == 16'd0) rx_state_q <= S_IDLE; else rx_cnt_q <= rx_cnt_q - 16'd1;
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart.sv
// tb_uart: directed + randomized bench for uart against a queue-based frame/register model.
module tb_uart;
  logic clk = 1'b0, reset_n = 1'b0, sel_in = 1'b0, uart_rx = 1'b1;
  logic [3:0] write_mask_in = 4'h0;
  logic [31:0] address_in = 32'h0, write_value_in = 32'h0;
  logic [31:0] read_value_out;
  logic uart_tx;
  int checks = 0, errors = 0;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  logic [7:0] rxq[$];
  bit m_ov = 1'b0, m_fe = 1'b0;

  uart dut (
    .clk(clk), .reset_n(reset_n), .sel_in(sel_in), .write_mask_in(write_mask_in),
    .address_in(address_in), .write_value_in(write_value_in), .read_value_out(read_value_out),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [3:0] m, input logic [31:0] v);
    sel_in = 1'b1; address_in = {28'h0, a, 2'b00}; write_mask_in = m; write_value_in = v;
    step();
    sel_in = 1'b0; write_mask_in = 4'h0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    sel_in = 1'b1; address_in = {28'h0, a, 2'b00}; write_mask_in = 4'h0;
    step();
    d = read_value_out;
    sel_in = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_rd(2'd1, d);
    chk(tag, d, {28'h0, m_fe, m_ov, 1'b0, rxq.size() != 0});
    m_ov = 1'b0; m_fe = 1'b0;
  endtask

  task automatic check_data(input string tag);
    logic [31:0] d, e;
    e = rxq.size() != 0 ? {24'h0, rxq.pop_front()} : 32'h0;
    bus_rd(2'd0, d);
    chk(tag, d, e);
  endtask

  // drive one 8N1 frame, then account for it in the model
  task automatic send_rx(input logic [7:0] b, input bit stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      step(div);
    end
    uart_rx = 1'b1;
    step(4);
    if (rxq.size() < CAP) rxq.push_back(b); else m_ov = 1'b1;
    if (!stop) m_fe = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] b, input int div, input bit disturb);
    logic [9:0] f;
    logic [31:0] d;
    f = {1'b1, b, 1'b0};
    bus_wr(2'd0, 4'h1, {24'h0, b});
    for (int i = 0; i < 10 * div; i++) begin
      chk("tx_bit", {31'h0, uart_tx}, {31'h0, f[i / div]});
      if (disturb && i == 3 * div + 1) chk("tx_busy_mid", {31'h0, read_value_out[1]}, 32'h1);
      if (disturb && i == 3 * div) begin
        sel_in = 1'b1; address_in = 32'h4; write_mask_in = 4'h0;
      end else if (disturb && i == 5 * div) begin
        sel_in = 1'b1; address_in = 32'h0; write_mask_in = 4'h1; write_value_in = {24'h0, ~b};
      end else begin
        sel_in = 1'b0; write_mask_in = 4'h0;
      end
      step();
    end
    sel_in = 1'b0; write_mask_in = 4'h0;
    chk("tx_idle_after", {31'h0, uart_tx}, 32'h1);
    bus_rd(2'd1, d);
    chk("tx_busy_after", {31'h0, d[1]}, 32'h0);
    m_ov = 1'b0; m_fe = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int div;
    logic [7:0] b;
    bit stop;
    step(3);
    chk("rst_tx", {31'h0, uart_tx}, 32'h1);
    reset_n = 1'b1;
    step();
    check_status("rst_status");
    bus_rd(2'd2, d);
    chk("rst_div", d, 32'd104);
    step();
    chk("rd_unselected_zero", read_value_out, 32'h0);
    chk("idle_tx", {31'h0, uart_tx}, 32'h1);
    bus_wr(2'd3, 4'hf, 32'hdeadbeef);
    bus_rd(2'd3, d);
    chk("reg3_zero", d, 32'h0);
    bus_wr(2'd2, 4'h3, 32'h2);
    bus_rd(2'd2, d);
    chk("div_clamp", d, 32'h4);
    bus_wr(2'd2, 4'h2, 32'h0000_0100);
    bus_rd(2'd2, d);
    chk("div_hi_byte", d, 32'h104);
    bus_wr(2'd2, 4'h3, 32'h8);
    bus_rd(2'd2, d);
    chk("div_8", d, 32'h8);

    send_tx(8'hA5, 8, 1'b1);

    send_rx(8'h3C, 1'b1, 8);
    check_status("rx_status");
    check_data("rx_data");
    check_status("rx_status_after");

    send_rx(8'h55, 1'b0, 8);
    check_status("fe_status");
    check_data("fe_data");
    check_status("fe_cleared");

    for (int i = 1; i <= CAP + 1; i++) send_rx(8'(i), 1'b1, 8);
    check_status("ovr_status");
    for (int i = 0; i < CAP; i++) check_data("ovr_data");
    check_status("ovr_cleared");

    repeat (4) begin
      div = $urandom_range(4, 12);
      bus_wr(2'd2, 4'h3, div);
      b = 8'($urandom);
      stop = $urandom_range(0, 3) != 0;
      send_rx(b, stop, div);
      check_status("rand_status");
      check_data("rand_data");
      check_status("rand_status_after");
      send_tx(8'($urandom), div, 1'b0);
    end

    bus_wr(2'd2, 4'h3, 32'h8);
    send_rx(8'h11, 1'b1, 8);
    bus_wr(2'd0, 4'h1, 32'h0);
    uart_rx = 1'b0;
    step(20);
    chk("pre_rst_tx_low", {31'h0, uart_tx}, 32'h0);
    reset_n = 1'b0;
    step();
    chk("mid_rst_tx", {31'h0, uart_tx}, 32'h1);
    uart_rx = 1'b1;
    rxq.delete();
    m_ov = 1'b0; m_fe = 1'b0;
    step(3);
    reset_n = 1'b1;
    step();
    check_status("post_rst_status");
    bus_rd(2'd2, d);
    chk("post_rst_div", d, 32'd104);
    chk("post_rst_tx", {31'h0, uart_tx}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
